// File: rtl/clkmon_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : clkmon_pkg                                                  |
// | Purpose  : Shared types and constants for the clk_sys monitor: FSM     |
// |            state encoding and the fault-code values.                   |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package clkmon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACQ    = 3'd1,
    ST_MEAS   = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_STALL = 2'b01;
  localparam logic [1:0] FC_FREQ  = 2'b10;
  localparam logic [1:0] FC_DUTY  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/clkmon_sync_edge.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : clkmon_sync_edge                                            |
// | Purpose  : 3-flop synchronizer for an asynchronous level, plus single- |
// |            cycle rise/fall pulses taken from the last two stages.      |
// | Ports    : clk, rst (sync, active-high), d_i (async level),            |
// |            rise_o / fall_o (1-cycle pulses, 2 clk after the edge).     |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module clkmon_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // s1 may go metastable; edges are judged only on the settled s2/s3 pair.
  assign rise_o =  s2_q & ~s3_q;
  assign fall_o = ~s2_q &  s3_q;

endmodule
`default_nettype wire

// File: rtl/clkdiv_monitor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : clkdiv_monitor                                              |
// | Purpose  : Checks the divided clock clk_sys (sampled as data in the    |
// |            clk domain): measures its period, declares lock after      |
// |            LOCK_CNT in-tolerance periods, flags stall / freq faults.   |
// | Ports    : clk, rst (sync, active-high), en, clk_sys_in               |
// |            period, period_vld, high_time, locked, fault, fault_code   |
// | Options  : CLKMON_DUTY_EN - measure high phase and flag duty faults   |
// |            (code 11) while locked; otherwise high_time is tied to 0.   |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module clkdiv_monitor
  import clkmon_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 6,
  parameter int TOL        = 1,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clk_sys_in,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic [CNT_W-1:0] high_time,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam logic signed [CNT_W:0] c_exp = (CNT_W+1)'(EXP_PERIOD);
  localparam logic signed [CNT_W:0] c_tol = (CNT_W+1)'(TOL);

  logic w_rise;
  logic w_fall;

  clkmon_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (clk_sys_in),
    .rise_o (w_rise),
    .fall_o (w_fall)
  );

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] good_q,   good_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             vld_q,    vld_d;
  logic             locked_q, locked_d;
  logic             fault_q,  fault_d;
  logic [1:0]       code_q,   code_d;
  logic [CNT_W-1:0] high_q,   high_d;

  // One extra bit keeps the subtraction signed without wrap for any cnt value.
  logic signed [CNT_W:0] w_freq_diff;
  logic                  w_freq_ok;
  logic                  w_timeout;
  logic                  w_duty_ok;

  assign w_freq_diff = $signed({1'b0, cnt_q}) - c_exp;
  assign w_freq_ok   = (w_freq_diff <= c_tol) && (w_freq_diff >= -c_tol);
  assign w_timeout   = (cnt_q == CNT_W'(TIMEOUT));

`ifdef CLKMON_DUTY_EN
  localparam logic signed [CNT_W:0] c_half = (CNT_W+1)'(EXP_PERIOD / 2);
  logic signed [CNT_W:0] w_duty_diff;
  assign w_duty_diff = $signed({1'b0, cnt_q}) - c_half;
  assign w_duty_ok   = (w_duty_diff <= c_tol) && (w_duty_diff >= -c_tol);
`else
  logic w_unused_fall;
  assign w_unused_fall = w_fall;
  assign w_duty_ok     = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    good_d   = good_q;
    period_d = period_q;
    vld_d    = 1'b0;
    locked_d = locked_q;
    fault_d  = fault_q;
    code_d   = code_q;
    high_d   = high_q;

    // cnt holds 1 in the cycle after a rise, so at the next rise it equals the period.
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (w_rise) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_ACQ;
      end
      ST_ACQ: begin
        if (w_rise) begin
          state_d = ST_MEAS;
        end else if (w_timeout) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = FC_STALL;
        end
      end
      ST_MEAS: begin
        if (w_rise) begin
          period_d = cnt_q;
          vld_d    = 1'b1;
          if (w_freq_ok) begin
            if (good_q + 1'b1 == CNT_W'(LOCK_CNT)) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end
            good_d = good_q + 1'b1;
          end else begin
            good_d = '0;
          end
        end else if (w_timeout) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = FC_STALL;
        end
`ifdef CLKMON_DUTY_EN
        else if (w_fall) begin
          high_d = cnt_q;
        end
`endif
      end
      ST_LOCKED: begin
        // Rise and fall never coincide, so FREQ naturally outranks DUTY.
        if (w_rise) begin
          period_d = cnt_q;
          vld_d    = 1'b1;
          if (!w_freq_ok) begin
            state_d  = ST_FAULT;
            fault_d  = 1'b1;
            locked_d = 1'b0;
            code_d   = FC_FREQ;
          end
        end else if (w_timeout) begin
          state_d  = ST_FAULT;
          fault_d  = 1'b1;
          locked_d = 1'b0;
          code_d   = FC_STALL;
        end
`ifdef CLKMON_DUTY_EN
        else if (w_fall) begin
          high_d = cnt_q;
          if (!w_duty_ok) begin
            state_d  = ST_FAULT;
            fault_d  = 1'b1;
            locked_d = 1'b0;
            code_d   = FC_DUTY;
          end
        end
`endif
      end
      ST_FAULT: begin
        locked_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Disabling the monitor discards every measurement and any sticky fault.
    if (!en) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      good_d   = '0;
      period_d = '0;
      vld_d    = 1'b0;
      locked_d = 1'b0;
      fault_d  = 1'b0;
      code_d   = FC_NONE;
      high_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      good_q   <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
      code_q   <= FC_NONE;
      high_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      period_q <= period_d;
      vld_q    <= vld_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
      high_q   <= high_d;
    end
  end

  assign period     = period_q;
  assign period_vld = vld_q;
  assign locked     = locked_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
`ifdef CLKMON_DUTY_EN
  assign high_time  = high_q;
`else
  assign high_time  = '0;
  logic [CNT_W-1:0] w_unused_high;
  assign w_unused_high = high_q;
`endif

endmodule
`default_nettype wire
